// File: rtl/LSU_pkg.sv
// Shared types and helpers for the load/store unit: FSM states, funct3 size
// encodings, byte-lane and store-data formatting.
package LSU_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_DONE   = 2'd2
  } lsu_state_e;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam int BE_W = 4;

  function automatic logic [BE_W-1:0] lane_be(input logic [2:0] f3, input logic [1:0] off);
    case (f3)
      F3_B, F3_BU: lane_be = 4'b0001 << off;
      F3_H, F3_HU: lane_be = 4'b0011 << off;
      default:     lane_be = 4'b1111;
    endcase
  endfunction

  // Unsigned sizes only exist for loads; stores with bu/hu are rejected.
  function automatic logic access_legal(input logic [2:0] f3, input logic [1:0] off,
                                        input logic is_store);
    case (f3)
      F3_B:    access_legal = 1'b1;
      F3_H:    access_legal = ~off[0];
      F3_W:    access_legal = (off == 2'b00);
      F3_BU:   access_legal = ~is_store;
      F3_HU:   access_legal = ~is_store & ~off[0];
      default: access_legal = 1'b0;
    endcase
  endfunction

  function automatic logic [31:0] store_lanes(input logic [2:0] f3, input logic [31:0] data);
    case (f3)
      F3_B:    store_lanes = {4{data[7:0]}};
      F3_H:    store_lanes = {2{data[15:0]}};
      default: store_lanes = data;
    endcase
  endfunction

endpackage

// File: rtl/load_extend.sv
// Combinational load alignment: picks the addressed byte/halfword out of the
// fetched word and sign- or zero-extends it according to funct3.
module load_extend
  import LSU_pkg::*;
(
  input  logic [2:0]  funct3_i,
  input  logic [1:0]  addr_i,
  input  logic [31:0] word_i,
  output logic [31:0] data_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = word_i[{addr_i, 3'b000} +: 8];
    half_sel = addr_i[1] ? word_i[31:16] : word_i[15:0];
    case (funct3_i)
      F3_B:    data_o = {{24{byte_sel[7]}}, byte_sel};
      F3_BU:   data_o = {24'd0, byte_sel};
      F3_H:    data_o = {{16{half_sel[15]}}, half_sel};
      F3_HU:   data_o = {16'd0, half_sel};
      default: data_o = word_i;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: turns one load or store per instruction into a single
// memory request, stalling the core until the response or a timeout abort.
module load_store_unit
  import LSU_pkg::*;
#(
  parameter int TIMEOUT = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            MemRead,
  input  logic            MemWrite,
  input  logic [2:0]      funct3,
  input  logic [31:0]     ALUResult,
  input  logic [31:0]     rd2,
  output logic [31:0]     ReadData,
  output logic            Stall,
  output logic            Fault,
  output logic            mem_req,
  output logic            mem_we,
  output logic [31:0]     mem_addr,
  output logic [31:0]     mem_wdata,
  output logic [BE_W-1:0] mem_be,
  input  logic            mem_ready,
  input  logic [31:0]     mem_rdata
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  lsu_state_e      state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]     read_data_q, read_data_d;
  logic            fault_q, fault_d;
  logic            req_q, req_d;
  logic            we_q, we_d;
  logic [31:0]     addr_q, addr_d;
  logic [31:0]     wdata_q, wdata_d;
  logic [BE_W-1:0] be_q, be_d;
  logic [2:0]      f3_q, f3_d;
  logic [1:0]      off_q, off_d;
  logic            stall_c;
  logic            access_c;
  logic            legal_c;
  logic [31:0]     load_word;

  load_extend u_load_extend (
    .funct3_i (f3_q),
    .addr_i   (off_q),
    .word_i   (mem_rdata),
    .data_o   (load_word)
  );

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path infers a latch.
    state_d     = state_q;
    cnt_d       = cnt_q;
    read_data_d = read_data_q;
    fault_d     = 1'b0;
    req_d       = req_q;
    we_d        = we_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    be_d        = be_q;
    f3_d        = f3_q;
    off_d       = off_q;
    stall_c     = 1'b0;
    access_c    = MemRead | MemWrite;
    legal_c     = ~(MemRead & MemWrite) & access_legal(funct3, ALUResult[1:0], MemWrite);

    case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        if (access_c && legal_c) begin
          stall_c = 1'b1;
          state_d = ST_ACCESS;
          req_d   = 1'b1;
          we_d    = MemWrite;
          addr_d  = {ALUResult[31:2], 2'b00};
          be_d    = lane_be(funct3, ALUResult[1:0]);
          wdata_d = MemWrite ? store_lanes(funct3, rd2) : 32'd0;
          f3_d    = funct3;
          off_d   = ALUResult[1:0];
        end else if (access_c) begin
          fault_d = 1'b1;
        end
      end
      ST_ACCESS: begin
        stall_c = 1'b1;
        if (mem_ready) begin
          req_d   = 1'b0;
          state_d = ST_DONE;
          if (!we_q) read_data_d = load_word;
        end else if (cnt_q == CNT_LAST) begin
          // Abort: no response within TIMEOUT cycles, report it as a fault.
          req_d       = 1'b0;
          fault_d     = 1'b1;
          read_data_d = 32'd0;
          state_d     = ST_DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_DONE: begin
        cnt_d   = '0;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples pre-edge values regardless of statement order.
    if (!rst) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      read_data_q <= 32'd0;
      fault_q     <= 1'b0;
      req_q       <= 1'b0;
      we_q        <= 1'b0;
      addr_q      <= 32'd0;
      wdata_q     <= 32'd0;
      be_q        <= '0;
      f3_q        <= 3'd0;
      off_q       <= 2'd0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      read_data_q <= read_data_d;
      fault_q     <= fault_d;
      req_q       <= req_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      be_q        <= be_d;
      f3_q        <= f3_d;
      off_q       <= off_d;
    end
  end

  assign Stall     = rst & stall_c;
  assign Fault     = fault_q;
  assign ReadData  = read_data_q;
  assign mem_req   = req_q;
  assign mem_we    = we_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign mem_be    = be_q;

endmodule
